// File: rtl/pipe_pkg.sv
// Shared pipeline-control types and constants for the hazard sequencer.
package pipe_pkg;

  typedef enum logic [0:0] {
    HZ_RUN     = 1'b0,
    HZ_MD_WAIT = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO           = 5'd0;
  localparam int         DEFAULT_MD_LATENCY = 4;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: an EX load whose destination feeds an ID source.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       lu
);

  // r0 is hardwired, so a load into it never produces a real dependency
  assign lu = ex_mem_read && (ex_rd != REG_ZERO) &&
              ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use stall, taken-branch squash, mul/div freeze,
// plus a saturating count of cycles in which the PC was held.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_LATENCY = DEFAULT_MD_LATENCY,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_md_start,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cycles
);

  hz_state_e  state;
  logic [3:0] cnt;
  logic       lu;

  hazard_detect u_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_rd      (ex_rd),
    .ex_mem_read(ex_mem_read),
    .lu         (lu)
  );

  // Mealy outputs; reset gates them so enables drop the instant reset_n falls
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    if (state == HZ_RUN) begin
      if (ex_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (ex_md_start) begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_bubble = 1'b1;
        md_busy      = 1'b1;
      end else if (lu) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end else begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
      md_busy    = 1'b1;
      if (cnt == 4'd0) md_done      = 1'b1;
      else             exmem_bubble = 1'b1;
    end
    if (!reset_n) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      md_busy      = 1'b0;
      md_done      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= HZ_RUN;
      cnt          <= 4'd0;
      stall_cycles <= '0;
    end else begin
      if (!pc_write && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
      case (state)
        HZ_RUN: begin
          // issue cycle counts as the first of MD_LATENCY frozen cycles
          if (!ex_branch_taken && ex_md_start) begin
            state <= HZ_MD_WAIT;
            cnt   <= 4'(MD_LATENCY - 2);
          end
        end
        default: begin
          if (cnt == 4'd0) state <= HZ_RUN;
          else             cnt   <= cnt - 4'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: single-cycle vector table plus mul/div, reset-abort and saturation sequences.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rt, ex_mem_read, ex_branch_taken, ex_md_start;
  logic        pc_write, ifid_write, idex_write, ifid_flush, idex_bubble;
  logic        exmem_bubble, md_busy, md_done;
  logic [15:0] stall_cycles;
  logic        s_pc_write, s_ifid_write, s_idex_write, s_ifid_flush, s_idex_bubble;
  logic        s_exmem_bubble, s_md_busy, s_md_done;
  logic [3:0]  s_stall_cycles;

  int npass = 0;
  int ntot  = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_md_start(ex_md_start), .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_write(idex_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_bubble(exmem_bubble), .md_busy(md_busy), .md_done(md_done),
    .stall_cycles(stall_cycles)
  );

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut_sat (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_md_start(ex_md_start), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .idex_write(s_idex_write), .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
    .exmem_bubble(s_exmem_bubble), .md_busy(s_md_busy), .md_done(s_md_done),
    .stall_cycles(s_stall_cycles)
  );

  // {pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exmem_bubble, md_busy, md_done}
  localparam logic [7:0] O_DEF  = 8'b1110_0000;
  localparam logic [7:0] O_LU   = 8'b0010_1000;
  localparam logic [7:0] O_BR   = 8'b1111_1000;
  localparam logic [7:0] O_MD   = 8'b0000_0110;
  localparam logic [7:0] O_DONE = 8'b0000_0011;
  localparam logic [7:0] O_RST  = 8'b0000_0000;

  typedef struct {
    string      name;
    logic [4:0] rs, rt, rd;
    logic       uses_rt, mem_read, br, md;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] outs();
    return {pc_write, ifid_write, idex_write, ifid_flush, idex_bubble,
            exmem_bubble, md_busy, md_done};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                       input logic [4:0] rd, input logic mem_read, input logic br,
                       input logic md);
    id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; ex_rd = rd;
    ex_mem_read = mem_read; ex_branch_taken = br; ex_md_start = md;
  endtask

  // Inputs are applied 1 time unit after a rising edge, outputs compared 1 later.
  task automatic step(input string name, input logic [7:0] exp);
    #1;
    chk({name, " outs"}, 32'(outs()), 32'(exp));
    chk({name, " stall_cycles"}, 32'(stall_cycles), 32'(exp_stall));
    @(posedge clk);
    if (!exp[7]) exp_stall++;
    #1;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    idle();
    #12;
    chk("reset outs", 32'(outs()), 32'(O_RST));
    chk("reset stall_cycles", 32'(stall_cycles), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    vecs.push_back('{"idle",        5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF});
    vecs.push_back('{"lu rs",       5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, O_LU});
    vecs.push_back('{"after lu",    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF});
    vecs.push_back('{"rt unused",   5'd1, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, O_DEF});
    vecs.push_back('{"rt used",     5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, O_LU});
    vecs.push_back('{"rd0 rs",      5'd0, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_DEF});
    vecs.push_back('{"rd0 rt",      5'd3, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, O_DEF});
    vecs.push_back('{"no load",     5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF});
    vecs.push_back('{"br over lu",  5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, O_BR});
    vecs.push_back('{"br over md",  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_BR});
    vecs.push_back('{"after br+md", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].rd,
            vecs[i].mem_read, vecs[i].br, vecs[i].md);
      step(vecs[i].name, vecs[i].exp);
    end

    // Two back-to-back mul/divs; lu and a branch during the freeze are ignored.
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); step("md1 c1", O_MD);
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0); step("md1 c2 lu", O_MD);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); step("md1 c3 br", O_MD);
    idle();                                           step("md1 c4", O_DONE);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); step("md2 c1", O_MD);
    idle();                                           step("md2 c2", O_MD);
    step("md2 c3", O_MD);
    step("md2 c4", O_DONE);
    step("after md", O_DEF);

    // Reset in the second cycle of the freeze aborts without md_done.
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); step("abort c1", O_MD);
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort outs", 32'(outs()), 32'(O_RST));
    chk("abort stall_cycles", 32'(stall_cycles), 32'd0);
    exp_stall = 0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) step("post abort", O_DEF);

    // Continuous load-use stall for 20 cycles: 4-bit counter pins at 15.
    drive(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("sat lu outs", 32'(outs()), 32'(O_LU));
      chk("sat count", 32'(s_stall_cycles), 32'((exp_stall > 15) ? 15 : exp_stall));
      @(posedge clk);
      exp_stall++;
      #1;
    end
    idle();
    #1;
    chk("sat final", 32'(s_stall_cycles), 32'd15);
    chk("wide final", 32'(stall_cycles), 32'(exp_stall));
    @(posedge clk); #2;
    chk("sat hold", 32'(s_stall_cycles), 32'd15);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
